jtag_debug_sys_pio_ctrl: RTL and testbench
==========================================

# jtag_debug_sys_pio_ctrl

Output-direction parallel I/O slave for the JTAG debug system. An Avalon-MM master writes a 32-bit output register that drives `out_port`, with per-byte write enables and a readback path. Each write that can change `out_port` retriggers a stretched `out_strobe` pulse so external logic knows fresh data is present. It is the write-side counterpart of the system's input PIO and sits on the same slave fabric.

## Interface
Parameters:
- `RESET_VALUE`, 32'h0000_0000: value loaded into the output register on reset.
- `STROBE_CYCLES`, 4: length of `out_strobe` in clocks. A value of 0 disables the strobe. The counter width is `$clog2(STROBE_CYCLES+1)`, minimum 1.

Ports:
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `address`  input  3: word address of the register.
- `chipselect`  input  1: slave select.
- `write_n`  input  1: active-low write strobe. A write is accepted when `chipselect && !write_n`.
- `writedata`  input  32: write data.
- `byteenable`  input  4: per-byte write qualifier; bit i enables `writedata[8i+7:8i]`.
- `readdata`  output  32: registered read data.
- `out_port`  output  32: the output register, driven directly.
- `out_strobe`  output  1: high while the strobe counter is nonzero.

## Operation
Register map:
- **0 DATA (RW).** Byte-enabled write replaces the enabled bytes of the output register.
- **1 STATUS (RO).** Bit 0 = `out_strobe`; bits 31:1 read as 0. Writes are ignored.
- **2, 3, 6, 7:** reserved. Reads return 0; writes are ignored.
- **4 OUTSET (WO), macro only.** `reg |= writedata & bytemask`. Reads return 0.
- **5 OUTCLEAR (WO), macro only.** `reg &= ~(writedata & bytemask)`. Reads return 0.

Data path:
- `bytemask` is each `byteenable` bit replicated 8 times.
- `out_port` always equals the output register.

Strobe counter:
- An accepted write to address 0, 4 or 5 loads the counter with `STROBE_CYCLES`. The load applies even if the data is unchanged or `byteenable` is 0, and it happens regardless of the current count (retrigger).
- Otherwise the counter decrements while it is nonzero, saturating at 0.
- Writes to addresses 4/5 with the macro off do not load the counter.

Read path:
- `readdata` is registered on every clock from the mux indexed by `address`.
- There is no read strobe, so reads have no side effects.

## Timing
- **Reset (asynchronous, immediate):**
  - output register = `RESET_VALUE`
  - `readdata` = 0
  - counter = 0, so `out_strobe` = 0
- **Write latency:** a write accepted at edge N updates `out_port` after edge N, and `out_strobe` rises at the same point. `out_strobe` stays high for exactly `STROBE_CYCLES` clocks, falling after edge N+`STROBE_CYCLES`.
- **Retrigger:** a second write at edge M restarts the count. The strobe then stays high through edge M+`STROBE_CYCLES` with no low gap.
- **Read latency:** 1 clock. `readdata` after edge N reflects the register state before edge N.
- **Simultaneous read and write at the same edge:** `readdata` captures the old value; the new value is visible one clock later.
- **Reset mid-strobe:** the counter clears immediately and `out_strobe` drops asynchronously.
- **Back-to-back writes:** accepted every cycle. There is no waitrequest, so the slave has zero wait states.

## Configuration
- **`PIO_CTRL_BITSET_EN` defined:** OUTSET/OUTCLEAR are decoded at addresses 4/5 and retrigger the strobe.
- **`PIO_CTRL_BITSET_EN` undefined:** addresses 4/5 behave as reserved (read 0, writes ignored, no strobe). No set/clear logic is synthesized.

## Test plan
- **Reset:** assert `reset_n`=0 mid-cycle with `RESET_VALUE`=32'hA5A5_0000 → `out_port`=32'hA5A5_0000, `readdata`=0 and `out_strobe`=0 immediately, without waiting for a clock edge.
- **Byte-enabled write and readback:** write 32'h1122_3344 to addr 0 with `byteenable`=4'b0101 over 0 → `out_port`=32'h0022_0044. Then read addr 0 → `readdata`=32'h0022_0044 one clock after the address is presented.
- **Strobe length:** with `STROBE_CYCLES`=4, a single write → `out_strobe` high for exactly 4 clocks. A second write 2 clocks later → `out_strobe` high continuously for 6 clocks total. STATUS bit 0 tracks `out_strobe`.
- **Set/clear (macro on):** from 32'h0000_00F0:
  - OUTSET 32'h0000_000F → `out_port`=32'h0000_00FF
  - OUTCLEAR 32'h0000_0030 → `out_port`=32'h0000_00CF
  - each write retriggers the strobe
- **Macro off:** OUTSET 32'hFFFF_FFFF → `out_port` unchanged, `out_strobe` stays 0, and reads of addr 4/5 return 0.
- **Reserved addresses and disabled strobe:** a write to addr 2 leaves `out_port` and the strobe unchanged. With `STROBE_CYCLES`=0, writes to addr 0 update `out_port` but `out_strobe` never asserts.

Source files
------------

// File: rtl/jtag_debug_sys_pio_ctrl.sv
// rtl/jtag_debug_sys_pio_ctrl.sv - Avalon-MM output PIO with byte enables, readback and stretched write strobe
// Optional OUTSET/OUTCLEAR registers at addresses 4/5 are built only when PIO_CTRL_BITSET_EN is defined.
module jtag_debug_sys_pio_ctrl #(
    parameter logic [31:0] RESET_VALUE   = 32'h0000_0000,
    parameter int          STROBE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic [31:0] out_port,
    output logic        out_strobe
);

    localparam int CW = (STROBE_CYCLES > 0) ? $clog2(STROBE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(STROBE_CYCLES);

    logic [31:0]   data_reg;
    logic [31:0]   data_next;
    logic [31:0]   bytemask;
    logic [31:0]   read_mux;
    logic [CW-1:0] count;
    logic          write_en;
    logic          load;

    assign write_en   = chipselect && !write_n;
    assign bytemask   = {{8{byteenable[3]}}, {8{byteenable[2]}},
                         {8{byteenable[1]}}, {8{byteenable[0]}}};
    assign out_port   = data_reg;
    assign out_strobe = (count != '0);

    always_comb begin
        data_next = data_reg;
        load      = 1'b0;
        if (write_en) begin
            case (address)
                3'd0: begin
                    data_next = (data_reg & ~bytemask) | (writedata & bytemask);
                    load      = 1'b1;
                end
`ifdef PIO_CTRL_BITSET_EN
                3'd4: begin
                    data_next = data_reg | (writedata & bytemask);
                    load      = 1'b1;
                end
                3'd5: begin
                    data_next = data_reg & ~(writedata & bytemask);
                    load      = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Write-only and reserved locations all read as zero.
    always_comb begin
        read_mux = 32'h0;
        case (address)
            3'd0:    read_mux = data_reg;
            3'd1:    read_mux = {31'h0, out_strobe};
            default: read_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
            readdata <= 32'h0;
            count    <= '0;
        end else begin
            data_reg <= data_next;
            readdata <= read_mux;
            // A load always wins so back-to-back writes stretch the strobe without a gap.
            if (load)
                count <= LOAD;
            else if (count != '0)
                count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_jtag_debug_sys_pio_ctrl.sv
// tb/tb_jtag_debug_sys_pio_ctrl.sv - directed scoreboard bench for jtag_debug_sys_pio_ctrl
module tb_jtag_debug_sys_pio_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic [31:0] readdata, out_port, readdata0, out_port0;
    logic        out_strobe, out_strobe0;

    always #5 clk = ~clk;

    jtag_debug_sys_pio_ctrl #(.RESET_VALUE(32'hA5A5_0000), .STROBE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .out_port(out_port), .out_strobe(out_strobe)
    );

    jtag_debug_sys_pio_ctrl #(.RESET_VALUE(32'h0000_0000), .STROBE_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata0), .out_port(out_port0), .out_strobe(out_strobe0)
    );

    int          passed = 0;
    int          total = 0;
    logic [31:0] model = 32'hA5A5_0000;
    logic [31:0] model0 = 32'h0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        strobe0_seen = 1'b0;

    always @(negedge clk) if (out_strobe0 === 1'b1) strobe0_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [31:0] mask_of(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (n) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be, input string tag);
        logic [31:0] m;
        m = mask_of(be);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d; byteenable = be;
        if (a == 3'd0) begin
            model  = (model & ~m) | (d & m);
            model0 = (model0 & ~m) | (d & m);
        end
`ifdef PIO_CTRL_BITSET_EN
        if (a == 3'd4) begin
            model  = model | (d & m);
            model0 = model0 | (d & m);
        end
        if (a == 3'd5) begin
            model  = model & ~(d & m);
            model0 = model0 & ~(d & m);
        end
`endif
        exp_q.push_back(model);
        tag_q.push_back(tag);
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        check(tag_q.pop_front(), out_port, exp_q.pop_front());
        check({tag, "_s0"}, out_port0, model0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] expv, input string tag);
        address = a;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        tick();
        check(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    initial begin
        int hi;
        logic fell, gap;
        logic [31:0] old;

        // Asynchronous reset applied between clock edges
        #2 reset_n = 1'b0;
        #1;
        check("rst_port", out_port, 32'hA5A5_0000);
        check("rst_rdata", readdata, 32'h0);
        check("rst_strobe", {31'h0, out_strobe}, 32'h0);
        check("rst_port_s0", out_port0, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        wr(3'd0, 32'h0000_0000, 4'hF, "wr_zero");
        wr(3'd0, 32'h1122_3344, 4'b0101, "wr_be0101");
        rd(3'd0, 32'h0022_0044, "rd_data");
        idle(6);

        // Single write: strobe high for exactly STROBE_CYCLES samples
        hi = 0; fell = 0; gap = 0;
        for (int i = 0; i < 12; i++) begin
            address = 3'd0; writedata = model; byteenable = 4'hF;
            chipselect = (i == 0); write_n = !(i == 0);
            tick();
            if (out_strobe) begin
                if (fell) gap = 1;
                hi++;
            end else if (hi > 0) fell = 1;
        end
        idle(1);
        check("strobe_len", 32'(hi), 32'd4);

        // Retrigger two clocks later: one continuous 6-clock pulse
        hi = 0; fell = 0; gap = 0;
        for (int i = 0; i < 14; i++) begin
            address = 3'd0; writedata = model; byteenable = 4'hF;
            chipselect = (i == 0 || i == 2); write_n = !(i == 0 || i == 2);
            tick();
            if (out_strobe) begin
                if (fell) gap = 1;
                hi++;
            end else if (hi > 0) fell = 1;
        end
        idle(1);
        check("retrig_len", 32'(hi), 32'd6);
        check("retrig_gap", {31'h0, gap}, 32'h0);

        // Zero byteenable changes nothing but still fires the strobe
        wr(3'd0, 32'hFFFF_FFFF, 4'h0, "wr_be0");
        check("be0_strobe", {31'h0, out_strobe}, 32'h1);
        rd(3'd1, 32'h1, "status_hi");
        idle(6);
        rd(3'd1, 32'h0, "status_lo");

        // Read and write at the same edge
        old = model;
        wr(3'd0, 32'hDEAD_BEEF, 4'hF, "wr_sim");
        check("rd_sim_old", readdata, old);
        tick();
        check("rd_sim_new", readdata, 32'hDEAD_BEEF);
        idle(6);

        wr(3'd2, 32'h1234_5678, 4'hF, "wr_res2");
        check("res2_strobe", {31'h0, out_strobe}, 32'h0);
        rd(3'd2, 32'h0, "rd_res2");

`ifdef PIO_CTRL_BITSET_EN
        wr(3'd0, 32'h0000_00F0, 4'hF, "wr_f0");
        idle(6);
        wr(3'd4, 32'h0000_000F, 4'hF, "outset");
        check("outset_strobe", {31'h0, out_strobe}, 32'h1);
        idle(6);
        wr(3'd5, 32'h0000_0030, 4'hF, "outclear");
        check("outclear_strobe", {31'h0, out_strobe}, 32'h1);
        check("outclear_val", out_port, 32'h0000_00CF);
        idle(6);
`else
        wr(3'd4, 32'hFFFF_FFFF, 4'hF, "outset_off");
        check("outset_off_strobe", {31'h0, out_strobe}, 32'h0);
        wr(3'd5, 32'hFFFF_FFFF, 4'hF, "outclear_off");
        check("outclear_off_strobe", {31'h0, out_strobe}, 32'h0);
`endif
        rd(3'd4, 32'h0, "rd_addr4");
        rd(3'd5, 32'h0, "rd_addr5");

        // Reset in the middle of a strobe
        wr(3'd0, 32'h1357_9BDF, 4'hF, "wr_pre_rst");
        tick();
        check("pre_rst_rdata", readdata, 32'h1357_9BDF);
        #2 reset_n = 1'b0;
        #1;
        model = 32'hA5A5_0000;
        model0 = 32'h0;
        check("midrst_strobe", {31'h0, out_strobe}, 32'h0);
        check("midrst_port", out_port, model);
        check("midrst_rdata", readdata, 32'h0);
        check("midrst_port_s0", out_port0, model0);
        tick();
        reset_n = 1'b1;
        tick();

        check("strobe0_never", {31'h0, strobe0_seen}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
